sparse_mem_loader: RTL

- Writer side of the sparse operand memory read by the polynomial-multiply controller.
- Accepts a stream of 16-bit sparse bit positions over a valid/ready handshake and packs them in pairs into 32-bit words: first position in [31:16] (high shift), second in [15:0] (low shift).
- Writes the words to consecutive sparse memory addresses starting at 0.
- Flags out-of-range positions and overflow, and signals completion so the multiply controller can be started.

---
 rtl/sparse_mem_loader.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/sparse_mem_loader.sv
// rtl/sparse_mem_loader.sv - packs a stream of sparse bit positions into pairs and writes them to the sparse operand memory
//
// Purpose:
//   Writer side of the sparse operand memory read by the polynomial-multiply
//   controller. Positions arrive on a valid/ready handshake and are packed two
//   per word: first position in [31:16], second in [15:0]. Words go to
//   consecutive addresses from 0. Out-of-range positions and memory overflow
//   raise a sticky error; load_done pulses when the load completes.
//
// Optional feature (compile-time macro SPARSE_ORDER_SWAP_EN):
//   When defined, each written word holds the smaller position in [31:16] so
//   the multiply controller's low-minus-high difference is non-negative.
//   Pairs padded with PAD_POS are never swapped. When undefined, halves are
//   written in arrival order.
//
// Ports:
//   clk                    in   clock
//   rst                    in   synchronous active-high reset
//   start                  in   begin a load (sampled in IDLE only)
//   pos_valid              in   position valid
//   pos_data[15:0]         in   sparse bit position
//   pos_last               in   final position of the stream
//   pos_ready              out  loader accepts a position this cycle
//   sparse_mem_write_en    out  one-cycle write strobe
//   sparse_mem_addr_o[9:0] out  write address
//   sparse_mem_write_data  out  packed pair
//   word_count[9:0]        out  words written in current/most recent load
//   load_done              out  one-cycle completion pulse
//   error                  out  sticky error, cleared by start or rst
//   busy                   out  high from start until load_done

module sparse_mem_loader #(
  parameter int          WORD_WIDTH      = 32,
  parameter int          MEM_SPARSE_SIZE = 50,
  parameter int          POLY_BITS       = 17669,
  parameter logic [15:0] PAD_POS         = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pos_valid,
  input  logic [15:0]           pos_data,
  input  logic                  pos_last,
  output logic                  pos_ready,
  output logic                  sparse_mem_write_en,
  output logic [9:0]            sparse_mem_addr_o,
  output logic [WORD_WIDTH-1:0] sparse_mem_write_data,
  output logic [9:0]            word_count,
  output logic                  load_done,
  output logic                  error,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_HI = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [16:0] LP_POLY_LIMIT = 17'(POLY_BITS);
  localparam logic [9:0]  LP_LAST_ADDR  = 10'(MEM_SPARSE_SIZE - 1);

  state_t                  r_state;
  logic [15:0]             r_hi;
  logic [9:0]              r_addr;
  logic                    r_last;
  logic                    r_pos_ready;
  logic                    r_write_en;
  logic [9:0]              r_wr_addr;
  logic [WORD_WIDTH-1:0]   r_wr_data;
  logic [9:0]              r_word_count;
  logic                    r_load_done;
  logic                    r_error;
  logic                    r_busy;

  logic                    w_accept;
  logic                    w_illegal;
  logic [15:0]             w_pair_hi;
  logic [15:0]             w_pair_lo;
  logic [WORD_WIDTH-1:0]   w_pair_data;

  assign w_accept  = pos_valid && r_pos_ready;
  assign w_illegal = ({1'b0, pos_data} >= LP_POLY_LIMIT);

  // The word is formed in the accepting cycle and registered into the write
  // port, so the strobe and data appear together in the WRITE cycle. A high
  // half accepted in WAIT_HI with pos_last comes straight from pos_data; an
  // illegal or missing low half is replaced by PAD_POS.
  always_comb begin
    w_pair_hi = (r_state == S_WAIT_HI) ? pos_data : r_hi;
    w_pair_lo = ((r_state == S_WAIT_HI) || w_illegal) ? PAD_POS : pos_data;
  end

`ifdef SPARSE_ORDER_SWAP_EN
  logic w_pair_pad;

  assign w_pair_pad = (r_state == S_WAIT_HI) || w_illegal;

  always_comb begin
    if (!w_pair_pad && (w_pair_hi > w_pair_lo)) begin
      w_pair_data = {w_pair_lo, w_pair_hi};
    end else begin
      w_pair_data = {w_pair_hi, w_pair_lo};
    end
  end
`else
  assign w_pair_data = {w_pair_hi, w_pair_lo};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_hi         <= '0;
      r_addr       <= '0;
      r_last       <= 1'b0;
      r_pos_ready  <= 1'b0;
      r_write_en   <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_word_count <= '0;
      r_load_done  <= 1'b0;
      r_error      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_write_en  <= 1'b0;
      r_load_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_WAIT_HI;
            r_busy       <= 1'b1;
            r_error      <= 1'b0;
            r_addr       <= '0;
            r_word_count <= '0;
            r_pos_ready  <= 1'b1;
          end
        end

        S_WAIT_HI: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_error <= 1'b1;
              if (pos_last) begin
                // Nothing held, so the stream ends without a write.
                r_state     <= S_DONE;
                r_pos_ready <= 1'b0;
                r_load_done <= 1'b1;
              end
            end else begin
              r_hi <= pos_data;
              if (pos_last) begin
                r_state     <= S_WRITE;
                r_pos_ready <= 1'b0;
                r_last      <= 1'b1;
                r_write_en  <= 1'b1;
                r_wr_addr   <= r_addr;
                r_wr_data   <= w_pair_data;
              end else begin
                r_state <= S_WAIT_LO;
              end
            end
          end
        end

        S_WAIT_LO: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_error <= 1'b1;
            end
            // A legal low half always completes the pair; an illegal one only
            // completes it (padded) when it also ends the stream.
            if (!w_illegal || pos_last) begin
              r_state     <= S_WRITE;
              r_pos_ready <= 1'b0;
              r_last      <= pos_last;
              r_write_en  <= 1'b1;
              r_wr_addr   <= r_addr;
              r_wr_data   <= w_pair_data;
            end
          end
        end

        S_WRITE: begin
          r_addr       <= r_addr + 10'd1;
          r_word_count <= r_word_count + 10'd1;
          if (r_last) begin
            r_state     <= S_DONE;
            r_load_done <= 1'b1;
          end else if (r_addr == LP_LAST_ADDR) begin
            // Memory full: stop here and leave the remaining stream undrained.
            r_state     <= S_DONE;
            r_error     <= 1'b1;
            r_load_done <= 1'b1;
          end else begin
            r_state     <= S_WAIT_HI;
            r_pos_ready <= 1'b1;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_last  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state     <= S_IDLE;
          r_pos_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign pos_ready             = r_pos_ready;
  assign sparse_mem_write_en   = r_write_en;
  assign sparse_mem_addr_o     = r_wr_addr;
  assign sparse_mem_write_data = r_wr_data;
  assign word_count            = r_word_count;
  assign load_done             = r_load_done;
  assign error                 = r_error;
  assign busy                  = r_busy;

endmodule
